core_dot_acc: RTL and testbench
===============================

Name: core_dot_acc

Overview:
- Parametrised streaming dot-product core for the transformer compute datapath.
- Each accepted beat carries LANES signed activation/weight pairs. The block multiplies the lanes and reduces them through an adder tree, then accumulates cfg_len beats into one wide sum.
- The sum is then arithmetic-shifted, saturated and returned as one output word.
- Sits between the operand buffers and the output writeback/softmax stages; valid/ready on both sides.

Parameters:
- LANES, 8, multiply lanes per beat (power of two, >=2)
- IDATA_W, 8, signed width of each activation/weight element
- ACC_W, 32, accumulator width (>= 2*IDATA_W+clog2(LANES))
- ODATA_W, 8, signed output width after quantisation
- LEN_W, 8, width of the beat-count configuration

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_len  in  LEN_W  beats per dot product; sampled on the first beat of a vector
- cfg_shift  in  5  right-shift amount; sampled on the first beat of a vector
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid&&in_ready
- in_act  in  LANES*IDATA_W  packed signed activations, lane 0 in the LSBs
- in_wgt  in  LANES*IDATA_W  packed signed weights, lane 0 in the LSBs
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  ODATA_W  signed quantised result
- out_sat  out  1  saturation occurred for this result
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high; the clock is clk and the reset is rst.
- Reset values: state=IDLE, accumulator=0, beat counter=0, out_valid=0, out_data=0, out_sat=0, busy=0. in_ready=0 while rst=1.
- FSM has four states: IDLE, ACC, DRAIN, HOLD. in_ready=1 only in IDLE and ACC.
- IDLE: on the first accepted beat, latch cfg_len (0 is treated as 1) and cfg_shift, set count=1, clear the accumulator. Go to DRAIN if len==1, else ACC.
- ACC: each accepted beat increments count. The beat making count==len moves the FSM to DRAIN. in_valid gaps (bubbles) stall the count and do not corrupt the sum. cfg changes during ACC are ignored.
- Pipeline stage 1 (P): registered per-lane signed products, 2*IDATA_W wide.
- Pipeline stage 2 (A): adder-tree sum, sign-extended to ACC_W and added into the accumulator. The accumulator wraps modulo 2^ACC_W; it does not saturate.
- Pipeline stage 3 (Q): arithmetic right shift by the latched shift, then saturate to [-2^(ODATA_W-1), 2^(ODATA_W-1)-1]. Registered into out_data/out_sat.
- DRAIN: fixed 2 cycles. Latency: last beat accepted in cycle t → out_valid=1 in cycle t+3.
- HOLD: out_valid=1. out_data/out_sat stay stable until out_valid&&out_ready, then IDLE next cycle with out_valid=0. No new beat is accepted in the handshake cycle.
- Reset mid-operation discards partial sums and any pending result; the next vector starts clean.
- Throughput: one vector per len+3 cycles when out_ready=1 and there are no bubbles.

Optional Feature:
- Macro: CORE_ROUND_EN
- Defined: when shift>0, add 2^(shift-1) before the arithmetic shift (round half toward +inf). Saturation is evaluated after rounding.
- Undefined: plain arithmetic shift (truncation toward -inf).
- Latency is identical in both builds.

Decomposition:
- Shared package core_pkg holds:
  - state enum (IDLE/ACC/DRAIN/HOLD)
  - localparam SUM_W = 2*IDATA_W+clog2(LANES)
  - DRAIN_CYCLES=2
  - a saturate function parametrised by input/output width
- Natural sub-module: core_adder_tree, a combinational parametrised reduction of LANES signed products to SUM_W.

Test Plan:
- Basic, len=1, shift=0: act all 1, wgt all 2 → out_data=16, out_sat=0, out_valid exactly 3 cycles after accept; cfg_len=0 gives the same result.
- Accumulate with bubbles, len=4, shift=12: act=wgt=127 all lanes, in_valid toggling every other cycle → acc=516128, out_data=126, result identical to the no-bubble run.
- Rounding, len=1, shift=2: act all 1, wgt={1,1,1,1,1,1,0,0} (sum 6) → out_data=1 without CORE_ROUND_EN, 2 with it.
- Saturation, len=2, shift=0: act=wgt=127 → out_data=127, out_sat=1. act=-128, wgt=127 → out_data=-128, out_sat=1.
- Backpressure: out_ready=0 for 10 cycles in HOLD → out_valid held, out_data stable, in_ready=0. After out_ready=1 → IDLE next cycle; next vector accepted the following cycle.
- Reset mid-ACC after 2 of 4 beats → out_valid=0, busy=0. A following len=1 vector (act 1, wgt 2) → out_data=16, free of stale sum.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared types and helpers for the streaming dot-product core.
//   state_t       : control FSM states (IDLE/ACC/DRAIN/HOLD)
//   SUM_W         : adder-tree result width for the default lane/data config
//   sum_width()   : same width computed for any LANES/IDATA_W pair
//   DRAIN_CYCLES  : cycles spent in DRAIN between the last beat and HOLD
//   saturate()    : clamp a sign-extended value to a signed output width
package core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int LANES_DEF    = 8;
    localparam int IDATA_W_DEF  = 8;
    localparam int SUM_W        = 2*IDATA_W_DEF + $clog2(LANES_DEF);
    localparam int DRAIN_CYCLES = 2;

    // Working width of the quantisation path; the accumulator is
    // sign-extended into it so rounding cannot overflow.
    localparam int QW = 64;

    function automatic int sum_width(input int lanes, input int idw);
        return 2*idw + $clog2(lanes);
    endfunction

    // Interpret the low in_w bits of x as signed, then clamp to the
    // range of an out_w-bit signed number.
    function automatic logic signed [QW-1:0] saturate(
        input logic signed [QW-1:0] x,
        input int                   in_w,
        input int                   out_w
    );
        logic signed [QW-1:0] xs, hi, lo;
        xs = (x <<< (QW - in_w)) >>> (QW - in_w);
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (xs > hi)      return hi;
        else if (xs < lo) return lo;
        else              return xs;
    endfunction

endpackage

// File: rtl/core_adder_tree.sv
// core_adder_tree: combinational binary reduction of LANES signed products.
//   i_prod : LANES packed signed products, 2*IDATA_W bits each, lane 0 at index 0
//   o_sum  : signed sum, TREE_W bits (wide enough that no overflow occurs)
module core_adder_tree
    import core_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int IDATA_W = 8,
    parameter int TREE_W  = 2*IDATA_W + $clog2(LANES)
) (
    input  logic [LANES-1:0][2*IDATA_W-1:0] i_prod,
    output logic [TREE_W-1:0]               o_sum
);

    // Heap layout: node k has children 2k+1 and 2k+2, leaves occupy
    // LANES-1 .. 2*LANES-2, root is node 0.
    localparam int NODES = 2*LANES - 1;

    logic [NODES-1:0][TREE_W-1:0] w_node;

    for (genvar g = 0; g < LANES; g++) begin : g_leaf
        assign w_node[LANES-1+g] = TREE_W'($signed(i_prod[g]));
    end

    // Equal-width two's-complement adds; TREE_W already covers the
    // full dynamic range so the sign is carried implicitly.
    for (genvar g = 0; g < LANES-1; g++) begin : g_node
        assign w_node[g] = w_node[2*g+1] + w_node[2*g+2];
    end

    assign o_sum = w_node[0];

endmodule

// File: rtl/core_dot_acc.sv
// core_dot_acc: streaming dot-product core with accumulate, shift and saturate.
//   clk, rst            : clock, synchronous active-high reset
//   cfg_len, cfg_shift  : beats per vector (0 => 1) and right shift, taken on the first beat
//   in_valid/in_ready   : operand beat handshake; in_act/in_wgt carry LANES signed pairs
//   out_valid/out_ready : result handshake; out_data signed result, out_sat clamp flag
//   busy                : FSM not in IDLE
// Build option CORE_ROUND_EN: round half toward +inf before the shift
// (when shift > 0); otherwise plain arithmetic shift. Latency is unchanged.
// Pipeline: P (products) -> A (tree + accumulate) -> Q (shift/saturate),
// so the result is valid three cycles after the last beat is accepted.
module core_dot_acc
    import core_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int IDATA_W = 8,
    parameter int ACC_W   = 32,
    parameter int ODATA_W = 8,
    parameter int LEN_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic [4:0]                 cfg_shift,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*IDATA_W-1:0]   in_act,
    input  logic [LANES*IDATA_W-1:0]   in_wgt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ODATA_W-1:0]         out_data,
    output logic                       out_sat,
    output logic                       busy
);

    localparam int PW    = 2*IDATA_W;
    localparam int W_SUM = sum_width(LANES, IDATA_W);

    state_t                  r_state, w_state_nxt;
    logic [LEN_W-1:0]        r_len, r_cnt, w_len_eff;
    logic [4:0]              r_shift;
    logic [1:0]              r_dcnt;
    logic                    w_accept;
    logic                    w_drain_last;

    logic [LANES-1:0][PW-1:0] w_prod, r_prod;
    logic                     r_p_vld, r_p_first;
    logic signed [W_SUM-1:0]  w_sum;
    logic signed [ACC_W-1:0]  r_acc;

    logic signed [QW-1:0]     w_q_ext, w_q_rnd, w_q_shf, w_q_val;

    // ---------------- handshake / status ----------------
    assign in_ready     = !rst && (r_state == IDLE || r_state == ACC);
    assign w_accept     = in_valid && in_ready;
    assign out_valid    = (r_state == HOLD);
    assign busy         = (r_state != IDLE);
    assign w_len_eff    = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign w_drain_last = (r_state == DRAIN) && (r_dcnt == 2'(DRAIN_CYCLES-1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_state_nxt = (w_len_eff == LEN_W'(1)) ? DRAIN : ACC;
            ACC:   if (w_accept && (r_cnt + LEN_W'(1) == r_len)) w_state_nxt = DRAIN;
            DRAIN: if (w_drain_last) w_state_nxt = HOLD;
            HOLD:  if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- per-lane multipliers ----------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [IDATA_W-1:0] w_a, w_b;
        assign w_a       = in_act[g*IDATA_W +: IDATA_W];
        assign w_b       = in_wgt[g*IDATA_W +: IDATA_W];
        assign w_prod[g] = PW'(w_a) * PW'(w_b);
    end

    core_adder_tree #(
        .LANES   (LANES),
        .IDATA_W (IDATA_W),
        .TREE_W  (W_SUM)
    ) u_tree (
        .i_prod (r_prod),
        .o_sum  (w_sum)
    );

    // ---------------- quantisation ----------------
    always_comb begin
        w_q_ext = QW'(r_acc);
`ifdef CORE_ROUND_EN
        w_q_rnd = (r_shift != 5'd0) ? w_q_ext + (64'sd1 <<< (r_shift - 5'd1)) : w_q_ext;
`else
        w_q_rnd = w_q_ext;
`endif
        w_q_shf = w_q_rnd >>> r_shift;
        w_q_val = saturate(w_q_shf, QW, ODATA_W);
    end

    // ---------------- datapath / counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len     <= '0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_dcnt    <= '0;
            r_prod    <= '0;
            r_p_vld   <= 1'b0;
            r_p_first <= 1'b0;
            r_acc     <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            // beat bookkeeping; config is frozen after the first beat
            if (w_accept && r_state == IDLE) begin
                r_len   <= w_len_eff;
                r_shift <= cfg_shift;
                r_cnt   <= LEN_W'(1);
            end else if (w_accept) begin
                r_cnt   <= r_cnt + LEN_W'(1);
            end

            r_dcnt <= (r_state == DRAIN) ? r_dcnt + 2'd1 : 2'd0;

            // stage P
            r_p_vld   <= w_accept;
            r_p_first <= w_accept && (r_state == IDLE);
            if (w_accept) r_prod <= w_prod;

            // stage A: the first beat of a vector overwrites instead of adding,
            // which is how the accumulator is cleared without a bubble
            if (r_p_vld)
                r_acc <= (r_p_first ? '0 : r_acc) + ACC_W'(w_sum);

            // stage Q: the accumulator holds the final sum in the last DRAIN cycle
            if (w_drain_last) begin
                out_data <= ODATA_W'(w_q_val);
                out_sat  <= (w_q_val != w_q_shf);
            end
        end
    end

endmodule

// File: tb/tb_core_dot_acc.sv
`timescale 1ns/1ps
module tb_core_dot_acc;

    localparam int LANES   = 8;
    localparam int IDATA_W = 8;
    localparam int ACC_W   = 32;
    localparam int ODATA_W = 8;
    localparam int LEN_W   = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [LEN_W-1:0]         cfg_len;
    logic [4:0]               cfg_shift;
    logic                     in_valid, in_ready;
    logic [LANES*IDATA_W-1:0] in_act, in_wgt;
    logic                     out_valid, out_ready;
    logic [ODATA_W-1:0]       out_data;
    logic                     out_sat, busy;

    core_dot_acc #(
        .LANES(LANES), .IDATA_W(IDATA_W), .ACC_W(ACC_W), .ODATA_W(ODATA_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    byte A [16][LANES];
    byte W [16][LANES];

    int last_acc_cyc;
    int last_wait;
    logic signed [63:0] last_data;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*IDATA_W-1:0] pack(input int b, input bit wgt);
        logic [LANES*IDATA_W-1:0] p;
        for (int l = 0; l < LANES; l++) p[l*IDATA_W +: IDATA_W] = wgt ? W[b][l] : A[b][l];
        return p;
    endfunction

    task automatic fill(input int nb, input int a, input int w);
        for (int b = 0; b < nb; b++)
            for (int l = 0; l < LANES; l++) begin
                A[b][l] = 8'(a);
                W[b][l] = 8'(w);
            end
    endtask

    // Present beat b and hold it until the DUT takes it.
    task automatic drive_beat(input int b, input int ln, input int sh);
        int waited = 0;
        in_act = pack(b, 1'b0); in_wgt = pack(b, 1'b1);
        cfg_len = LEN_W'(ln); cfg_shift = 5'(sh); in_valid = 1'b1;
        while (!in_ready && waited < 100) begin @(posedge clk); #1; waited++; end
        if (waited >= 100) begin
            checks++; errors++;
            $error("FAIL accept_timeout: observed=%0d expected=<100", waited);
        end
        @(posedge clk); #1;
        last_acc_cyc = cyc - 1;
        last_wait    = waited;
        in_valid     = 1'b0;
    endtask

    // Drive one vector from A/W and compute its expected result from the
    // plain dot product of all beats (accumulator wraps at ACC_W bits).
    task automatic send_vec(input int ln, input int sh, input bit bubbles,
                            output logic signed [63:0] exp_d, output logic exp_s);
        int eff = (ln == 0) ? 1 : ln;
        longint dot = 0;
        logic signed [ACC_W-1:0] accw;
        longint v;
        for (int b = 0; b < eff; b++) begin
            for (int l = 0; l < LANES; l++) dot += longint'(A[b][l]) * longint'(W[b][l]);
            if (b == 0) drive_beat(b, ln, sh);
            else        drive_beat(b, int'($urandom_range(0, 255)), int'($urandom_range(0, 31)));
            if (bubbles && b < eff-1) begin @(posedge clk); #1; end
        end
        accw = ACC_W'(dot);
        v    = longint'(accw);
`ifdef CORE_ROUND_EN
        if (sh > 0) v += (64'sd1 <<< (sh - 1));
`endif
        v = v >>> sh;
        exp_s = (v > 127) || (v < -128);
        exp_d = (v > 127) ? 64'sd127 : (v < -128) ? -64'sd128 : v;
    endtask

    task automatic get_result(input logic signed [63:0] exp_d, input logic exp_s,
                              input bit chk_lat, input string tag);
        int g = 0;
        while (!out_valid && g < 100) begin @(posedge clk); #1; g++; end
        chk({tag, "_valid"}, 64'(out_valid), 64'sd1);
        if (chk_lat) chk({tag, "_lat"}, 64'(cyc - last_acc_cyc), 64'sd3);
        chk({tag, "_data"}, 64'($signed(out_data)), exp_d);
        chk({tag, "_sat"}, 64'(out_sat), 64'(exp_s));
        last_data = 64'($signed(out_data));
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, "_release"}, 64'(out_valid), 64'sd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic signed [63:0] ed, nb_data;
        logic es;
        int c0, rel_cyc, held;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cfg_len = '0; cfg_shift = '0; in_act = '0; in_wgt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'sd0);
        chk("rst_out_valid", 64'(out_valid), 64'sd0);
        chk("rst_out_data",  64'(out_data),  64'sd0);
        chk("rst_out_sat",   64'(out_sat),   64'sd0);
        chk("rst_busy",      64'(busy),      64'sd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", 64'(in_ready), 64'sd1);

        // basic len=1, then len=0 treated as 1, back to back
        fill(1, 1, 2);
        send_vec(1, 0, 1'b0, ed, es);
        c0 = last_acc_cyc;
        get_result(ed, es, 1'b1, "basic");
        chk("basic_const", last_data, 64'sd16);
        send_vec(0, 0, 1'b0, ed, es);
        chk("throughput", 64'(last_acc_cyc - c0), 64'sd4);
        get_result(ed, es, 1'b1, "len0");
        chk("len0_const", last_data, 64'sd16);

        // accumulate, with and without bubbles
        fill(4, 127, 127);
        send_vec(4, 12, 1'b0, ed, es);
        get_result(ed, es, 1'b1, "acc_nb");
        chk("acc_nb_const", last_data, 64'sd126);
        nb_data = last_data;
        send_vec(4, 12, 1'b1, ed, es);
        get_result(ed, es, 1'b1, "acc_bub");
        chk("acc_bub_same", last_data, nb_data);

        // rounding
        fill(1, 1, 1);
        W[0][0] = 8'sd0; W[0][1] = 8'sd0;
        send_vec(1, 2, 1'b0, ed, es);
        get_result(ed, es, 1'b1, "round");
`ifdef CORE_ROUND_EN
        chk("round_const", last_data, 64'sd2);
`else
        chk("round_const", last_data, 64'sd1);
`endif

        // saturation both ways
        fill(2, 127, 127);
        send_vec(2, 0, 1'b0, ed, es);
        get_result(ed, es, 1'b1, "sat_pos");
        chk("sat_pos_const", last_data, 64'sd127);
        fill(2, -128, 127);
        send_vec(2, 0, 1'b0, ed, es);
        get_result(ed, es, 1'b1, "sat_neg");
        chk("sat_neg_const", last_data, -64'sd128);

        // backpressure in HOLD
        out_ready = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int l = 0; l < LANES; l++) begin A[b][l] = 8'($urandom); W[b][l] = 8'($urandom); end
        send_vec(2, 7, 1'b0, ed, es);
        get_result(ed, es, 1'b1, "bp");
        held = int'(last_data);
        fill(1, 1, 2);
        in_act = pack(0, 1'b0); in_wgt = pack(0, 1'b1);
        cfg_len = 8'd1; cfg_shift = 5'd0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", 64'(out_valid), 64'sd1);
            chk("bp_data_stable", 64'($signed(out_data)), 64'(held));
            chk("bp_in_ready", 64'(in_ready), 64'sd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        rel_cyc = cyc;
        chk("bp_release_valid", 64'(out_valid), 64'sd0);
        chk("bp_release_busy", 64'(busy), 64'sd0);
        send_vec(1, 0, 1'b0, ed, es);
        chk("bp_next_wait", 64'(last_wait), 64'sd0);
        chk("bp_next_cycle", 64'(last_acc_cyc), 64'(rel_cyc));
        get_result(ed, es, 1'b1, "bp_next");
        chk("bp_next_const", last_data, 64'sd16);

        // reset in the middle of a 4-beat vector
        for (int b = 0; b < 4; b++)
            for (int l = 0; l < LANES; l++) begin A[b][l] = 8'($urandom); W[b][l] = 8'($urandom); end
        drive_beat(0, 4, 0);
        drive_beat(1, 4, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", 64'(out_valid), 64'sd0);
        chk("mid_rst_busy", 64'(busy), 64'sd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'sd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 64'(busy), 64'sd0);
        fill(1, 1, 2);
        send_vec(1, 0, 1'b0, ed, es);
        get_result(ed, es, 1'b1, "post_rst");
        chk("post_rst_const", last_data, 64'sd16);

        // randomized vectors against the reference model
        for (int t = 0; t < 30; t++) begin
            int ln, sh;
            ln = int'($urandom_range(1, 6));
            sh = int'($urandom_range(0, 20));
            for (int b = 0; b < ln; b++)
                for (int l = 0; l < LANES; l++) begin A[b][l] = 8'($urandom); W[b][l] = 8'($urandom); end
            send_vec(ln, sh, 1'($urandom_range(0, 1)), ed, es);
            get_result(ed, es, 1'b1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
